// File: rtl/serial_compare_pkg.sv
// Shared types for the serial magnitude-compare sequencer and its compare step.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package serial_compare_pkg;

    // Handshake/sequencing FSM state of the top level.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    // Decision state of the MSB-first compare step.
    typedef enum logic [1:0] {
        CMP_EQUAL   = 2'd0,
        CMP_LESS    = 2'd1,
        CMP_GREATER = 2'd2
    } cmp_state_t;

    // One-hot compare result: exactly one field is set for a valid result.
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_msb_compare_step.sv
// One-bit-per-cycle MSB-first magnitude compare step with a sticky decision.
// Latency: outputs are combinational on the current bit while still EQUAL; decision registers on en.
// Backpressure: none; advances only when en is high, clear forces EQUAL.
module serial_msb_compare_step
    import serial_compare_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic a_less_b,
    output logic a_eq_b,
    output logic a_greater_b
);

    cmp_state_t state_q;
    cmp_state_t state_d;

    // Next decision: the first differing bit wins, later bits are ignored.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = CMP_EQUAL;
        end else if (en && (state_q == CMP_EQUAL)) begin
            if (a && !b) begin
                state_d = CMP_GREATER;
            end else if (!a && b) begin
                state_d = CMP_LESS;
            end
        end
    end

    // Decision register with synchronous reset to EQUAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CMP_EQUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // While undecided, fold the bit being presented into the outputs so the
    // sequencer can latch the final answer in the same cycle as the LSB.
    always_comb begin
        a_less_b    = 1'b0;
        a_eq_b      = 1'b0;
        a_greater_b = 1'b0;
        case (state_q)
            CMP_LESS:    a_less_b    = 1'b1;
            CMP_GREATER: a_greater_b = 1'b1;
            default: begin
                a_less_b    = en & ~a & b;
                a_greater_b = en & a & ~b;
                a_eq_b      = ~(en & (a ^ b));
            end
        endcase
    end

endmodule

// File: rtl/serial_compare_sequencer.sv
// Accepts an operand pair, shifts it MSB-first through a serial compare step, returns one-hot lt/eq/gt.
// Latency: accept at T, result valid at T+WIDTH+1; minimum accept period WIDTH+2 cycles.
// Backpressure: in_ready only in idle; result held frozen while out_ready is low.
module serial_compare_sequencer
    import serial_compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a_less_b,
    output logic             out_a_eq_b,
    output logic             out_a_greater_b
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    seq_state_t      state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    cmp_result_t     result_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [CW-1:0]   cnt_q;

    logic        accept;
    logic        cmp_clear;
    logic        cmp_en;
    cmp_result_t cmp_res;

    // Accept strobe doubles as the compare-step clear; en only ever runs in
    // the shift phase, so clear and en can never coincide.
    always_comb begin
        accept    = in_ready_q & in_valid & ~rst & (state_q == ST_IDLE);
        cmp_clear = accept;
        cmp_en    = (state_q == ST_SHIFT);
    end

    serial_msb_compare_step u_step (
        .clk         (clk),
        .rst         (rst),
        .clear       (cmp_clear),
        .en          (cmp_en),
        .a           (sh_a_q[WIDTH-1]),
        .b           (sh_b_q[WIDTH-1]),
        .a_less_b    (cmp_res.lt),
        .a_eq_b      (cmp_res.eq),
        .a_greater_b (cmp_res.gt)
    );

    // Sequencing FSM with its datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sh_a_q     <= in_a;
                        sh_b_q     <= in_b;
                        cnt_q      <= CNT_LOAD;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sh_a_q <= sh_a_q << 1;
                    sh_b_q <= sh_b_q << 1;
                    if (cnt_q == '0) begin
                        // LSB is on the compare step right now: capture final answer.
                        result_q    <= cmp_res;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is masked during the reset cycle itself so nothing is accepted then.
    always_comb begin
        in_ready        = in_ready_q & ~rst;
        out_valid       = out_valid_q;
        out_a_less_b    = result_q.lt;
        out_a_eq_b      = result_q.eq;
        out_a_greater_b = result_q.gt;
    end

endmodule
